// File: rtl/accel_buffer_pkg.sv
// Types and defaults shared by set_packer and ring_buffer.
// A set is DATA_OF_SET lanes of DATA_WIDTH bits; lane 0 holds the first element.
package accel_buffer_pkg;

    localparam int unsigned DEF_DATA_OF_SET = 4;
    localparam int unsigned DEF_DATA_WIDTH  = 8;
    localparam int unsigned DEF_CNT_WIDTH   = 16;

    typedef logic [DEF_DATA_OF_SET-1:0][DEF_DATA_WIDTH-1:0] set_t;

    typedef enum logic {
        StEmpty,
        StPend
    } pend_state_e;

endpackage

// File: rtl/set_packer.sv
// Packs a serial element stream into fixed-width sets for ring_buffer.
// A single pending-set register decouples assembly from full_flag back-pressure.
module set_packer
    import accel_buffer_pkg::*;
#(
    parameter int unsigned DATA_OF_SET = DEF_DATA_OF_SET,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [DATA_WIDTH-1:0]                  s_data,
    input  logic                                   s_last,
    input  logic                                   full_flag,
    output logic                                   wen,
    output logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] din,
    output logic [CNT_WIDTH-1:0]                   set_count,
    output logic                                   busy
);

    localparam int unsigned LaneW = $clog2(DATA_OF_SET);
    localparam logic [LaneW-1:0] LastLane = LaneW'(DATA_OF_SET - 1);

    typedef logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] lanes_t;

    pend_state_e          state_q, state_d;
    logic [LaneW-1:0]     lane_idx_q, lane_idx_d;
    lanes_t               lanes_q, lanes_d;
    lanes_t               pend_data_q, pend_data_d;
    lanes_t               assembled;
    logic [CNT_WIDTH-1:0] set_count_q, set_count_d;
    logic                 pend_valid;
    logic                 accept;
    logic                 complete;

    always_comb begin
        pend_valid = (state_q == StPend);
        s_ready    = !(pend_valid && full_flag);
        wen        = pend_valid && !full_flag;
        accept     = s_valid && s_ready;
        complete   = accept && ((lane_idx_q == LastLane) || s_last);

        // Lanes above the incoming element are zero so an early s_last yields a padded set.
        assembled             = lanes_q;
        assembled[lane_idx_q] = s_data;
        for (int unsigned i = 0; i < DATA_OF_SET; i++) begin
            if (LaneW'(i) > lane_idx_q) begin
                assembled[i] = '0;
            end
        end

        state_d     = state_q;
        lane_idx_d  = lane_idx_q;
        lanes_d     = lanes_q;
        pend_data_d = pend_data_q;
        set_count_d = set_count_q;

        if (wen) begin
            set_count_d = set_count_q + CNT_WIDTH'(1);
            state_d     = StEmpty;
        end

        if (accept) begin
            if (complete) begin
                pend_data_d = assembled;
                state_d     = StPend;
                lane_idx_d  = '0;
                lanes_d     = '0;
            end else begin
                lanes_d    = assembled;
                lane_idx_d = lane_idx_q + LaneW'(1);
            end
        end

        din       = pend_data_q;
        set_count = set_count_q;
        busy      = (lane_idx_q != '0) || pend_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            lane_idx_q  <= '0;
            lanes_q     <= '0;
            pend_data_q <= '0;
            set_count_q <= '0;
        end else begin
            state_q     <= state_d;
            lane_idx_q  <= lane_idx_d;
            lanes_q     <= lanes_d;
            pend_data_q <= pend_data_d;
            set_count_q <= set_count_d;
        end
    end

endmodule

// File: tb/tb_set_packer.sv
// Directed and randomized bench for set_packer; ring_buffer is modelled as an occupancy
// counter of depth 4 and expected sets come from a queue-based packing model.
module tb_set_packer;

    localparam int BufSize = 4;

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       s_data;
    logic             s_last;
    logic             full_flag;
    logic             wen;
    logic [3:0][7:0]  din;
    logic [15:0]      set_count;
    logic             busy;

    set_packer #(
        .DATA_OF_SET(4),
        .DATA_WIDTH (8),
        .CNT_WIDTH  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .full_flag(full_flag),
        .wen      (wen),
        .din      (din),
        .set_count(set_count),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [7:0]  partial[$];
    logic [31:0] held[$];
    int          occ;
    logic [15:0] cnt;
    logic [31:0] last_din;
    int          n_pass;
    int          n_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pack_partial();
        logic [3:0][7:0] s;
        s = '0;
        for (int i = 0; i < partial.size(); i++) s[i] = partial[i];
        return s;
    endfunction

    // One clock cycle: drive, check at mid-cycle, advance the model, cross the edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic rd);
        logic exp_ready;
        logic exp_wen;
        logic rd_ok;
        rst       = 1'b0;
        s_valid   = v;
        s_data    = d;
        s_last    = l;
        full_flag = (occ >= BufSize);
        #4;
        exp_ready = !(held.size() != 0 && full_flag);
        exp_wen   = (held.size() != 0) && !full_flag;
        chk("s_ready", 32'(s_ready), 32'(exp_ready));
        chk("wen", 32'(wen), 32'(exp_wen));
        chk("busy", 32'(busy), 32'(partial.size() != 0 || held.size() != 0));
        chk("set_count", 32'(set_count), 32'(cnt));
        if (exp_wen) begin
            chk("din", din, held[0]);
            last_din = din;
        end
        rd_ok = rd && (occ > 0);
        if (exp_wen) begin
            void'(held.pop_front());
            cnt++;
        end
        occ = occ + int'(exp_wen) - int'(rd_ok);
        if (v && exp_ready) begin
            partial.push_back(d);
            if (partial.size() == 4 || l) begin
                held.push_back(pack_partial());
                partial.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v);
        rst       = 1'b1;
        s_valid   = v;
        s_data    = 8'hee;
        s_last    = 1'b0;
        full_flag = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_valid = 1'b0;
        partial.delete();
        held.delete();
        cnt = '0;
        occ = 0;
        #4;
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_din", din, 32'd0);
        chk("rst_set_count", 32'(set_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        occ = 0;
        cnt = '0;
        last_din = '0;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        full_flag = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        do_reset(1'b0);

        // Four back-to-back elements form one full set
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("set1_din", last_din, 32'h04030201);
        chk("set1_count", 32'(set_count), 32'd1);

        // Early s_last pads the upper lanes
        cycle(1'b1, 8'h05, 1'b0, 1'b0);
        cycle(1'b1, 8'h06, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("partial_din", last_din, 32'h00000605);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("partial_busy", 32'(busy), 32'd0);

        // Fill the buffer, stall, free one slot, stall again, then drain
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("full_s_ready", 32'(s_ready), 32'd0);
        cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Sixteen continuous elements with the buffer draining every cycle
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic: valid, s_last and reads all random
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0));
        end

        // Reset mid-set discards the partial set
        do_reset(1'b0);
        cycle(1'b1, 8'h07, 1'b0, 1'b1);
        cycle(1'b1, 8'h08, 1'b0, 1'b1);
        do_reset(1'b1);
        for (int i = 9; i <= 12; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("after_rst_din", last_din, 32'h0c0b0a09);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("final_set_count", 32'(set_count), 32'(cnt));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
